// File: rtl/uart_fifo_bridge.sv
// rtl/uart_fifo_bridge.sv - CPU byte bridge to a polled UART via TX/RX FIFOs; UART_FIFO_BRIDGE_IRQ_EN adds O_irq
module uart_fifo_bridge #(
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 4
) (
    input  logic       I_wb_clk,
    input  logic       I_reset_n,
    input  logic [1:0] I_wb_adr,
    input  logic [7:0] I_wb_dat,
    input  logic       I_wb_stb,
    input  logic       I_wb_we,
    output logic       O_wb_ack,
    output logic [7:0] O_wb_dat,
    output logic [1:0] O_m_adr,
    output logic [7:0] O_m_dat,
    output logic       O_m_stb,
    output logic       O_m_we,
    input  logic       I_m_ack,
    input  logic [7:0] I_m_dat
`ifdef UART_FIFO_BRIDGE_IRQ_EN
    ,
    output logic       O_irq
`endif
);

    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam int TX_CNT_W = TX_DEPTH_LOG2 + 1;
    localparam int RX_CNT_W = RX_DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_POLL,
        ST_RX_READ,
        ST_TX_POLL,
        ST_TX_WRITE,
        ST_WAIT
    } state_t;

    state_t state;
    state_t pend;
    logic   prio_rx;
    logic   uart_idle;

    logic [7:0]               tx_mem [TX_DEPTH];
    logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr;
    logic [TX_DEPTH_LOG2-1:0] tx_rd_ptr;
    logic [TX_CNT_W-1:0]      tx_count;
    logic [7:0]               rx_mem [RX_DEPTH];
    logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr;
    logic [RX_DEPTH_LOG2-1:0] rx_rd_ptr;
    logic [RX_CNT_W-1:0]      rx_count;

    logic       tx_empty, tx_full, rx_empty, rx_full, tx_idle;
    logic       cpu_accept, cpu_rd;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic [1:0] irq_en_rd;
    logic [7:0] status;
    logic [7:0] rd_data;

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == TX_CNT_W'(TX_DEPTH));
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == RX_CNT_W'(RX_DEPTH));
    assign tx_idle  = tx_empty && uart_idle;

    assign cpu_accept = I_wb_stb && !O_wb_ack;
    assign cpu_rd     = cpu_accept && !I_wb_we;

    // A full FIFO still takes a push when the same cycle pops it.
    assign tx_pop  = (state == ST_TX_WRITE) && !tx_empty;
    assign tx_push = cpu_accept && I_wb_we && (I_wb_adr == 2'd0) && (!tx_full || tx_pop);
    assign rx_pop  = cpu_rd && (I_wb_adr == 2'd0) && !rx_empty;
    assign rx_push = (state == ST_WAIT) && (pend == ST_RX_READ) && I_m_ack && (!rx_full || rx_pop);

    assign status = {3'b000, irq_en_rd, tx_idle, !tx_full, !rx_empty};

    always_comb begin
        rd_data = 8'h00;
        case (I_wb_adr)
            2'd0:    if (!rx_empty) rd_data = rx_mem[rx_rd_ptr];
            2'd1:    rd_data = status;
            2'd2:    rd_data = 8'(rx_count);
            default: rd_data = 8'(tx_count);
        endcase
    end

    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            O_wb_ack <= 1'b0;
            O_wb_dat <= 8'h00;
        end else begin
            O_wb_ack <= cpu_accept;
            O_wb_dat <= cpu_rd ? rd_data : 8'h00;
        end
    end

`ifdef UART_FIFO_BRIDGE_IRQ_EN
    logic [1:0] irq_en;

    assign irq_en_rd = irq_en;

    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            irq_en <= 2'b00;
            O_irq  <= 1'b0;
        end else begin
            if (cpu_accept && I_wb_we && (I_wb_adr == 2'd1))
                irq_en <= I_wb_dat[1:0];
            O_irq <= (irq_en[0] && !rx_empty) || (irq_en[1] && tx_idle);
        end
    end
`else
    assign irq_en_rd = 2'b00;
`endif

    always_ff @(posedge I_wb_clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= I_wb_dat;
        if (rx_push) rx_mem[rx_wr_ptr] <= I_m_dat;
    end

    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_DEPTH_LOG2'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_DEPTH_LOG2'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + TX_CNT_W'(1);
                2'b01:   tx_count <= tx_count - TX_CNT_W'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_DEPTH_LOG2'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_DEPTH_LOG2'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + RX_CNT_W'(1);
                2'b01:   rx_count <= rx_count - RX_CNT_W'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Strobe states last one cycle; WAIT remembers which one issued the request.
    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state     <= ST_IDLE;
            pend      <= ST_IDLE;
            prio_rx   <= 1'b1;
            uart_idle <= 1'b1;
            O_m_stb   <= 1'b0;
            O_m_we    <= 1'b0;
            O_m_adr   <= 2'd0;
            O_m_dat   <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_full && (prio_rx || tx_empty)) begin
                        state   <= ST_RX_POLL;
                        O_m_stb <= 1'b1;
                        O_m_we  <= 1'b0;
                        O_m_adr <= 2'd1;
                        prio_rx <= 1'b0;
                    end else if (!tx_empty) begin
                        state   <= ST_TX_POLL;
                        O_m_stb <= 1'b1;
                        O_m_we  <= 1'b0;
                        O_m_adr <= 2'd2;
                        prio_rx <= 1'b1;
                    end
                end
                ST_RX_POLL, ST_RX_READ, ST_TX_POLL: begin
                    pend    <= state;
                    state   <= ST_WAIT;
                    O_m_stb <= 1'b0;
                end
                ST_TX_WRITE: begin
                    pend      <= ST_TX_WRITE;
                    state     <= ST_WAIT;
                    O_m_stb   <= 1'b0;
                    O_m_we    <= 1'b0;
                    uart_idle <= 1'b0;
                end
                ST_WAIT: begin
                    if (I_m_ack) begin
                        state <= ST_IDLE;
                        case (pend)
                            ST_RX_POLL: begin
                                if (I_m_dat[0]) begin
                                    state   <= ST_RX_READ;
                                    O_m_stb <= 1'b1;
                                    O_m_we  <= 1'b0;
                                    O_m_adr <= 2'd0;
                                end
                            end
                            ST_TX_POLL: begin
                                uart_idle <= I_m_dat[0];
                                if (I_m_dat[0]) begin
                                    state   <= ST_TX_WRITE;
                                    O_m_stb <= 1'b1;
                                    O_m_we  <= 1'b1;
                                    O_m_adr <= 2'd0;
                                    O_m_dat <= tx_mem[tx_rd_ptr];
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb/tb_uart_fifo_bridge.sv - randomized bench for uart_fifo_bridge against a queue-based UART/FIFO model
module tb_uart_fifo_bridge;

    logic       I_wb_clk = 1'b0;
    logic       I_reset_n;
    logic [1:0] I_wb_adr;
    logic [7:0] I_wb_dat;
    logic       I_wb_stb;
    logic       I_wb_we;
    logic       O_wb_ack;
    logic [7:0] O_wb_dat;
    logic [1:0] O_m_adr;
    logic [7:0] O_m_dat;
    logic       O_m_stb;
    logic       O_m_we;
    logic       I_m_ack;
    logic [7:0] I_m_dat;
`ifdef UART_FIFO_BRIDGE_IRQ_EN
    logic       O_irq;
`endif

    uart_fifo_bridge dut (
        .I_wb_clk  (I_wb_clk),
        .I_reset_n (I_reset_n),
        .I_wb_adr  (I_wb_adr),
        .I_wb_dat  (I_wb_dat),
        .I_wb_stb  (I_wb_stb),
        .I_wb_we   (I_wb_we),
        .O_wb_ack  (O_wb_ack),
        .O_wb_dat  (O_wb_dat),
        .O_m_adr   (O_m_adr),
        .O_m_dat   (O_m_dat),
        .O_m_stb   (O_m_stb),
        .O_m_we    (O_m_we),
        .I_m_ack   (I_m_ack),
        .I_m_dat   (I_m_dat)
`ifdef UART_FIFO_BRIDGE_IRQ_EN
        ,
        .O_irq     (O_irq)
`endif
    );

    always #5 I_wb_clk = ~I_wb_clk;

    int cycle = 0;
    always @(posedge I_wb_clk) cycle <= cycle + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // UART model: bytes offered to the bridge, bytes it transmitted, readiness flags.
    logic [7:0] rx_src[$];
    int         rx_rd_idx = 0;
    logic [7:0] tx_log[$];
    bit         tx_ready = 1'b0;
    bit         idle_m = 1'b1;
    int         poll_viol = 0;
    int         first_wr_cycle = -1;
    int         late_req = 0;

    initial begin
        logic [7:0] resp;
        bit         pend;
        bit         poll_ok;
        int         dly;
        int         late_done;
        resp = 8'h00; pend = 1'b0; poll_ok = 1'b0; dly = 0; late_done = 0;
        I_m_ack = 1'b0;
        I_m_dat = 8'h00;
        forever begin
            @(negedge I_wb_clk);
            if (!I_reset_n) begin
                I_m_ack = 1'b0;
                I_m_dat = 8'h00;
                pend    = 1'b0;
                poll_ok = 1'b0;
            end else begin
                if (I_m_ack) begin
                    I_m_ack = 1'b0;
                    I_m_dat = 8'h00;
                end
                if (late_req != late_done) begin
                    late_done = late_req;
                    I_m_ack = 1'b1;
                    I_m_dat = 8'hFF;
                end else if (O_m_stb) begin
                    pend = 1'b1;
                    dly  = $urandom_range(0, 2);
                    resp = 8'h00;
                    if (O_m_we) begin
                        if (O_m_adr == 2'd0) begin
                            if (!poll_ok) poll_viol++;
                            tx_log.push_back(O_m_dat);
                            idle_m = 1'b0;
                            if (first_wr_cycle < 0) first_wr_cycle = cycle;
                        end
                        poll_ok = 1'b0;
                    end else begin
                        poll_ok = 1'b0;
                        case (O_m_adr)
                            2'd1: resp = {7'b0, rx_src.size() > rx_rd_idx};
                            2'd2: begin
                                resp    = {7'b0, tx_ready};
                                idle_m  = tx_ready;
                                poll_ok = tx_ready;
                            end
                            2'd0: if (rx_src.size() > rx_rd_idx) begin
                                resp = rx_src[rx_rd_idx];
                                rx_rd_idx++;
                            end
                            default: resp = 8'h00;
                        endcase
                    end
                end else if (pend) begin
                    if (dly == 0) begin
                        I_m_ack = 1'b1;
                        I_m_dat = resp;
                        pend    = 1'b0;
                    end else begin
                        dly--;
                    end
                end
            end
        end
    end

    task automatic cpu_access(input bit we, input logic [1:0] adr, input logic [7:0] wdat,
                              output logic [7:0] rdat);
        int t;
        t = 0;
        @(posedge I_wb_clk); #1;
        I_wb_stb = 1'b1;
        I_wb_we  = we;
        I_wb_adr = adr;
        I_wb_dat = wdat;
        do begin
            @(posedge I_wb_clk); #1;
            t++;
        end while (!O_wb_ack && t < 8);
        check_eq("wb_ack", O_wb_ack, 1);
        rdat = O_wb_dat;
        I_wb_stb = 1'b0;
        I_wb_we  = 1'b0;
        @(posedge I_wb_clk); #1;
        check_eq("wb_ack_one_cycle", O_wb_ack, 0);
    endtask

    task automatic cpu_write(input logic [1:0] adr, input logic [7:0] d);
        logic [7:0] dummy;
        cpu_access(1'b1, adr, d, dummy);
    endtask

    task automatic cpu_read(input logic [1:0] adr, output logic [7:0] d);
        cpu_access(1'b0, adr, 8'h00, d);
    endtask

    task automatic check_outputs_reset(input string tag);
        check_eq({tag, "_wb_ack"}, O_wb_ack, 0);
        check_eq({tag, "_wb_dat"}, O_wb_dat, 0);
        check_eq({tag, "_m_stb"},  O_m_stb, 0);
        check_eq({tag, "_m_we"},   O_m_we, 0);
        check_eq({tag, "_m_adr"},  O_m_adr, 0);
        check_eq({tag, "_m_dat"},  O_m_dat, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] b;
        logic [7:0] exp_tx[$];
        logic [7:0] exp_rx[$];
        logic [7:0] e;
        int         t0;
        int         base;
        int         n;
        int         model_tx_occ;

        I_reset_n = 1'b0;
        I_wb_stb  = 1'b0;
        I_wb_we   = 1'b0;
        I_wb_adr  = 2'd0;
        I_wb_dat  = 8'h00;
        repeat (3) @(posedge I_wb_clk);
        #1;
        check_outputs_reset("rst0");
        I_reset_n = 1'b1;

        cpu_read(2'd1, d);  check_eq("rst_adr1", d, 8'h06);
        cpu_read(2'd2, d);  check_eq("rst_adr2", d, 8'h00);
        cpu_read(2'd3, d);  check_eq("rst_adr3", d, 8'h00);

        // Two bytes out through a ready UART.
        tx_ready = 1'b1;
        t0 = cycle;
        cpu_write(2'd0, 8'h41);
        cpu_write(2'd0, 8'h42);
        for (int i = 0; i < 300 && tx_log.size() < 2; i++) @(posedge I_wb_clk);
        #1;
        check_eq("tx2_count", tx_log.size(), 2);
        if (tx_log.size() >= 2) begin
            check_eq("tx2_byte0", tx_log[0], 8'h41);
            check_eq("tx2_byte1", tx_log[1], 8'h42);
        end
        check_eq("tx_latency_bound", (first_wr_cycle >= 0) && (first_wr_cycle - t0 <= 16), 1);
        cpu_read(2'd1, d);
        check_eq("adr1_after_tx", d, {5'b0, idle_m, 1'b1, 1'b0});

        // One byte in from the UART.
        rx_src.push_back(8'h55);
        for (int i = 0; i < 300 && rx_rd_idx < rx_src.size(); i++) @(posedge I_wb_clk);
        repeat (10) @(posedge I_wb_clk);
        cpu_read(2'd2, d);  check_eq("rx1_count", d, 8'h01);
        cpu_read(2'd0, d);  check_eq("rx1_data", d, 8'h55);
        cpu_read(2'd0, d);  check_eq("rx1_empty_read", d, 8'h00);
        cpu_read(2'd2, d);  check_eq("rx1_count_after", d, 8'h00);

        // Randomized mix of CPU writes, UART offers, drains and readiness changes.
        base = tx_log.size();
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: if (exp_tx.size() - (tx_log.size() - base) < 12) begin
                    b = 8'($urandom);
                    cpu_write(2'd0, b);
                    exp_tx.push_back(b);
                end
                1: if (exp_rx.size() < 10) begin
                    b = 8'($urandom);
                    rx_src.push_back(b);
                    exp_rx.push_back(b);
                end
                2: begin
                    cpu_read(2'd2, d);
                    n = d;
                    check_eq("rx_count_bound", n <= exp_rx.size(), 1);
                    for (int k = 0; k < n && exp_rx.size() > 0; k++) begin
                        cpu_read(2'd0, d);
                        e = exp_rx.pop_front();
                        check_eq("rand_rx_data", d, e);
                    end
                end
                default: begin
                    tx_ready = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(1, 6)) @(posedge I_wb_clk);
                end
            endcase
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 3000 && (tx_log.size() - base < exp_tx.size() || rx_rd_idx < rx_src.size()); i++)
            @(posedge I_wb_clk);
        repeat (10) @(posedge I_wb_clk);
        check_eq("rand_tx_count", tx_log.size() - base, exp_tx.size());
        for (int k = 0; k < exp_tx.size() && base + k < tx_log.size(); k++)
            check_eq("rand_tx_data", tx_log[base + k], exp_tx[k]);
        cpu_read(2'd2, d);
        check_eq("rand_rx_final_count", d, exp_rx.size());
        while (exp_rx.size() > 0) begin
            cpu_read(2'd0, d);
            e = exp_rx.pop_front();
            check_eq("rand_rx_final_data", d, e);
        end
        cpu_read(2'd0, d);  check_eq("rand_rx_empty_read", d, 8'h00);
        check_eq("tx_poll_before_write", poll_viol, 0);

        // Overflow: UART never ready, 17 writes into a 16-deep FIFO.
        tx_ready = 1'b0;
        base = tx_log.size();
        model_tx_occ = 0;
        for (int k = 0; k < 17; k++) begin
            cpu_write(2'd0, 8'(8'h80 + k));
            if (model_tx_occ < 16) model_tx_occ++;
        end
        repeat (10) @(posedge I_wb_clk);
        cpu_read(2'd3, d);  check_eq("ovf_adr3", d, model_tx_occ);
        cpu_read(2'd1, d);  check_eq("ovf_adr1", d, 8'h00);
        check_eq("ovf_none_sent", tx_log.size(), base);

        // Reset while waiting on a UART ack, then a stale ack after release.
        for (int i = 0; i < 100 && !O_m_stb; i++) begin
            @(posedge I_wb_clk); #1;
        end
        check_eq("wait_seen_stb", O_m_stb, 1);
        @(posedge I_wb_clk); #1;
        I_reset_n = 1'b0;
        #1;
        check_outputs_reset("rst_wait");
        @(posedge I_wb_clk); #1;
        check_outputs_reset("rst_wait_clk");
        late_req++;
        I_reset_n = 1'b1;
        repeat (20) @(posedge I_wb_clk);
        cpu_read(2'd2, d);  check_eq("post_rst_adr2", d, 8'h00);
        cpu_read(2'd3, d);  check_eq("post_rst_adr3", d, 8'h00);
        cpu_read(2'd1, d);  check_eq("post_rst_adr1", d, 8'h06);
        check_eq("post_rst_none_sent", tx_log.size(), base);

`ifdef UART_FIFO_BRIDGE_IRQ_EN
        cpu_write(2'd1, 8'h01);
        cpu_read(2'd1, d);  check_eq("irq_adr1_en", d, 8'h0E);
        rx_src.push_back(8'h33);
        for (int i = 0; i < 300 && rx_rd_idx < rx_src.size(); i++) @(posedge I_wb_clk);
        repeat (10) @(posedge I_wb_clk);
        #1;
        check_eq("irq_set", O_irq, 1);
        cpu_read(2'd0, d);  check_eq("irq_rx_data", d, 8'h33);
        #1;
        check_eq("irq_clear", O_irq, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_fifo_bridge.md
UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 SHALL have parameter TX_DEPTH_LOG2, default 4, TX FIFO depth = 2**TX_DEPTH_LOG2 bytes.
REQ-002 SHALL have parameter RX_DEPTH_LOG2, default 4, RX FIFO depth = 2**RX_DEPTH_LOG2 bytes.
REQ-003 I_wb_clk  in  1  single clock; all logic on rising edge.
REQ-004 I_reset_n  in  1  asynchronous, active-low reset.
REQ-005 I_wb_adr  in  2  CPU-side register select.
REQ-006 I_wb_dat  in  8  CPU write data.
REQ-007 I_wb_stb  in  1  CPU access strobe.
REQ-008 I_wb_we  in  1  CPU write enable.
REQ-009 O_wb_ack  out  1  CPU access acknowledge.
REQ-010 O_wb_dat  out  8  CPU read data.
REQ-011 O_m_adr  out  2  UART-side address: 0 data, 1 RX status, 2 TX status.
REQ-012 O_m_dat  out  8  UART-side write data.
REQ-013 O_m_stb  out  1  UART-side strobe.
REQ-014 O_m_we  out  1  UART-side write enable.
REQ-015 I_m_ack  in  1  UART-side acknowledge.
REQ-016 I_m_dat  in  8  UART-side read data; bit0 = ready flag on status reads.

Function
REQ-017 CPU access SHALL be accepted on a cycle with I_wb_stb=1 and O_wb_ack=0; O_wb_ack SHALL be 1 for exactly the following cycle, carrying O_wb_dat.
REQ-018 Write adr0: push I_wb_dat into TX FIFO; if full, data dropped, still acked.
REQ-019 Read adr0: pop RX FIFO head to O_wb_dat; if empty, return 0x00, no pointer change.
REQ-020 Read adr1: {5'b0, tx_empty_and_uart_idle, tx_not_full, rx_not_empty}.
REQ-021 Read adr2/adr3: RX/TX FIFO occupancy (0..depth), zero-extended to 8 bits.
REQ-022 Writes to adr1..3 SHALL have no effect (except REQ-034).
REQ-023 Same-cycle push and pop on one FIFO SHALL both take effect; occupancy unchanged; full FIFO with simultaneous pop SHALL accept the push.
REQ-024 Pointers SHALL wrap modulo depth; occupancy counter width = DEPTH_LOG2+1.
REQ-025 UART-side FSM states: IDLE, RX_POLL, RX_READ, TX_POLL, TX_WRITE, WAIT.
REQ-026 Each UART transaction SHALL drive O_m_stb=1 for exactly one cycle, then hold O_m_stb=0 in WAIT until I_m_ack=1; no new transaction on the ack cycle.
REQ-027 IDLE SHALL alternate priority RX/TX each transaction; RX candidate if RX FIFO not full, TX candidate if TX FIFO not empty; neither -> stay IDLE.
REQ-028 RX_POLL reads adr1; ack with I_m_dat[0]=1 -> RX_READ (read adr0, push I_m_dat into RX FIFO on ack); else -> IDLE.
REQ-029 TX_POLL reads adr2; ack with I_m_dat[0]=1 -> TX_WRITE (write TX FIFO head to adr0, pop on strobe cycle); else -> IDLE.
REQ-030 uart_idle flag SHALL be updated from each TX_POLL result and cleared on each TX_WRITE.
REQ-031 Latency: byte in empty TX FIFO, FSM IDLE, UART ready -> O_m_stb with O_m_we=1 within 8 cycles.

Reset
REQ-032 While I_reset_n=0: O_wb_ack=0, O_wb_dat=0, O_m_stb=0, O_m_we=0, O_m_adr=0, O_m_dat=0, FIFOs empty, FSM IDLE, priority=RX, uart_idle=1.
REQ-033 Reset mid-transaction SHALL abandon it; an I_m_ack arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-034 Macro UART_FIFO_BRIDGE_IRQ_EN defined: output O_irq (1 bit), 2-bit enable reg written via adr1 bits[1:0], reset 0; O_irq = (en[0]&rx_not_empty)|(en[1]&tx_empty_and_uart_idle), registered; adr1 read bits[4:3] = en. Undefined: no O_irq port, adr1 writes ignored, bits[4:3] read 0.

Verification
REQ-035 Reset release, CPU reads adr1 -> 0x06; adr2, adr3 -> 0x00.
REQ-036 CPU writes 0x41,0x42; UART model status ready -> two adr0 writes, O_m_dat 0x41 then 0x42, each preceded by an adr2 poll.
REQ-037 UART model offers 0x55 (adr1 bit0=1) -> RX FIFO count 1; CPU read adr0 -> 0x55; next read -> 0x00.
REQ-038 17 CPU writes with UART status never ready, depth 16 -> adr3 reads 0x10, 17th byte never transmitted.
REQ-039 Assert I_reset_n=0 in WAIT with O_m_stb already pulsed -> all outputs per REQ-032 next cycle, late I_m_ack ignored.
REQ-040 With UART_FIFO_BRIDGE_IRQ_EN, write adr1=0x01, UART delivers 0x33 -> O_irq=1; CPU pops -> O_irq=0.
